// File: rtl/mem_stage_mmio.sv
// MEM stage: synchronous data RAM plus a memory-mapped I/O window (LEDs, switches, cycle counter).
// Loads complete one cycle after the request; misaligned accesses are dropped and latch a sticky fault.
module mem_stage_mmio #(
  parameter int DATA_W    = 64,
  parameter int RAM_DEPTH = 1024,
  parameter int IO_BIT    = 15,
  parameter int SW_W      = 18,
  parameter int LED_W     = 27
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic [SW_W-1:0]   switches,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [LED_W-1:0]  leds,
  output logic              addr_fault
);

  localparam int AW = $clog2(RAM_DEPTH);

  typedef enum logic [1:0] {
    REG_LED  = 2'd0,
    REG_SW   = 2'd1,
    REG_CNT  = 2'd2,
    REG_RSVD = 2'd3
  } io_reg_e;

  logic [DATA_W-1:0] ram_q [RAM_DEPTH];

  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              read_valid_q, read_valid_d;
  logic [DATA_W-1:0] alu_result_out_q;
  logic [LED_W-1:0]  leds_q, leds_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              run_q;
  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;

  logic              aligned, is_ram, wr_ok, rd_ok, ram_we, cnt_clr;
  logic [AW-1:0]     ram_idx;
  io_reg_e           io_sel;
  logic              unused_addr;

  assign aligned     = (alu_result[2:0] == 3'b000);
  assign is_ram      = (alu_result[DATA_W-1:IO_BIT] == '0);
  assign ram_idx     = alu_result[3 +: AW];
  assign io_sel      = io_reg_e'(alu_result[4:3]);
  assign wr_ok       = mem_write & aligned;
  assign rd_ok       = mem_read & aligned & ~mem_write;
  assign ram_we      = wr_ok & is_ram;
  assign cnt_clr     = wr_ok & ~is_ram & (io_sel == REG_CNT);
  assign unused_addr = ^alu_result[IO_BIT-1:3];

  // run_q holds the counter still on the first edge after reset release
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (run_q) begin
      cnt_d = cnt_q + DATA_W'(1);
    end
  end

  // A counter read returns the value the counter holds after the read's edge
  always_comb begin
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    leds_d       = leds_q;
    fault_d      = fault_q | ((mem_read | mem_write) & ~aligned);
    if (wr_ok) begin
      if (!is_ram && io_sel == REG_LED) begin
        leds_d = write_data[LED_W-1:0];
      end
    end else if (rd_ok) begin
      read_valid_d = 1'b1;
      if (is_ram) begin
        read_data_d = ram_q[ram_idx];
      end else begin
        case (io_sel)
          REG_LED:  read_data_d = DATA_W'(leds_q);
          REG_SW:   read_data_d = DATA_W'(sw_sync_q);
          REG_CNT:  read_data_d = cnt_d;
          default:  read_data_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram_q[ram_idx] <= write_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q      <= '0;
      read_valid_q     <= 1'b0;
      alu_result_out_q <= '0;
      leds_q           <= '0;
      fault_q          <= 1'b0;
      cnt_q            <= '0;
      run_q            <= 1'b0;
      sw_meta_q        <= '0;
      sw_sync_q        <= '0;
    end else begin
      read_data_q      <= read_data_d;
      read_valid_q     <= read_valid_d;
      alu_result_out_q <= alu_result;
      leds_q           <= leds_d;
      fault_q          <= fault_d;
      cnt_q            <= cnt_d;
      run_q            <= 1'b1;
      sw_meta_q        <= switches;
      sw_sync_q        <= sw_meta_q;
    end
  end

  assign read_data      = read_data_q;
  assign read_valid     = read_valid_q;
  assign alu_result_out = alu_result_out_q;
  assign leds           = leds_q;
  assign addr_fault     = fault_q;

endmodule

// File: tb/tb_mem_stage_mmio.sv
// Directed, table-driven bench for mem_stage_mmio with hand sequences for reset and counter wrap.
module tb_mem_stage_mmio;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        memWrite, memRead;
  logic [63:0] aluResult, writeData;
  logic [17:0] switches;
  logic [63:0] readData, aluResultOut;
  logic        readValid, addrFault;
  logic [26:0] leds;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [17:0] sw;
    logic        expValid;
    logic [63:0] expData;
    logic [26:0] expLeds;
    logic        expFault;
  } vec_t;

  vec_t vecs[$];

  mem_stage_mmio #(
    .DATA_W(64), .RAM_DEPTH(1024), .IO_BIT(15), .SW_W(18), .LED_W(27)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .mem_write(memWrite),
    .mem_read(memRead),
    .alu_result(aluResult),
    .write_data(writeData),
    .switches(switches),
    .read_data(readData),
    .read_valid(readValid),
    .alu_result_out(aluResultOut),
    .leds(leds),
    .addr_fault(addrFault)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic wr, input logic rd, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [17:0] sw,
                              input logic expValid, input logic [63:0] expData,
                              input logic [26:0] expLeds, input logic expFault);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.sw = sw;
    v.expValid = expValid; v.expData = expData; v.expLeds = expLeds; v.expFault = expFault;
    return v;
  endfunction

  task automatic checkOne(input string name, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checkOne({tag, ".read_valid"}, 64'(readValid), 64'(v.expValid));
    checkOne({tag, ".read_data"}, readData, v.expData);
    checkOne({tag, ".alu_result_out"}, aluResultOut, v.addr);
    checkOne({tag, ".leds"}, 64'(leds), 64'(v.expLeds));
    checkOne({tag, ".addr_fault"}, 64'(addrFault), 64'(v.expFault));
  endtask

  // Drive at the falling edge, check 1 time unit after the rising edge, return at the next falling edge
  task automatic applyStimulus(input vec_t v, input string tag);
    memWrite  = v.wr;
    memRead   = v.rd;
    aluResult = v.addr;
    writeData = v.wdata;
    switches  = v.sw;
    @(posedge clock);
    #1;
    checkOutput(v, tag);
    @(negedge clock);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOne({tag, ".read_data"}, readData, 64'h0);
    checkOne({tag, ".read_valid"}, 64'(readValid), 64'h0);
    checkOne({tag, ".alu_result_out"}, aluResultOut, 64'h0);
    checkOne({tag, ".leds"}, 64'(leds), 64'h0);
    checkOne({tag, ".addr_fault"}, 64'(addrFault), 64'h0);
  endtask

  localparam logic [63:0] BEEF  = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [26:0] LMAX  = 27'h7FF_FFFF;
  localparam logic [17:0] SWNEW = 18'h2AAAA;

  initial begin
    //          wr    rd    addr          wdata                  sw     vld   data          leds  fault
    vecs.push_back(mk(1'b0, 1'b1, 64'h8010, 64'h0,                 18'h0, 1'b1, 64'h0,        27'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 64'h8010, 64'h0,                 18'h0, 1'b1, 64'h1,        27'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 64'h8010, 64'h0,                 18'h0, 1'b1, 64'h2,        27'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 64'h40,   BEEF,                  18'h0, 1'b0, 64'h2,        27'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 64'h40,   64'h0,                 18'h0, 1'b1, BEEF,         27'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 64'h2040, 64'h0,                 18'h0, 1'b1, BEEF,         27'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 64'h0,    64'h0,                 18'h0, 1'b0, BEEF,         27'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 64'h8000, 64'hFFFF_FFFF_FFFF_FFFF, 18'h0, 1'b0, BEEF,       LMAX,  1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 64'h8000, 64'h0,                 18'h0, 1'b1, 64'(LMAX),    LMAX,  1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 64'h8008, 64'h0,                 18'h0, 1'b0, 64'(LMAX),    LMAX,  1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 64'h8018, 64'h0,                 18'h0, 1'b0, 64'(LMAX),    LMAX,  1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 64'h8018, 64'h0,                 18'h0, 1'b1, 64'h0,        LMAX,  1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 64'h8010, 64'h0,                 18'h0, 1'b0, 64'h0,        LMAX,  1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 64'h8010, 64'h0,                 18'h0, 1'b1, 64'h1,        LMAX,  1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 64'h8010, 64'h0,                 18'h0, 1'b1, 64'h2,        LMAX,  1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 64'h48,   64'h1234,              18'h0, 1'b0, 64'h2,        LMAX,  1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 64'h48,   64'h0,                 18'h0, 1'b1, 64'h1234,     LMAX,  1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 64'h40,   64'h5555,              18'h0, 1'b0, 64'h1234,     LMAX,  1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 64'h40,   64'h0,                 18'h0, 1'b1, 64'h5555,     LMAX,  1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 64'h44,   64'hBAD,               18'h0, 1'b0, 64'h5555,     LMAX,  1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 64'h40,   64'h0,                 18'h0, 1'b1, 64'h5555,     LMAX,  1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 64'h41,   64'h0,                 18'h0, 1'b0, 64'h5555,     LMAX,  1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 64'h8001, 64'h0,                 18'h0, 1'b0, 64'h5555,     LMAX,  1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 64'h8000, 64'h0,                 18'h0, 1'b1, 64'(LMAX),    LMAX,  1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 64'h0,    64'h0,                 SWNEW, 1'b0, 64'(LMAX),    LMAX,  1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 64'h8008, 64'h0,                 SWNEW, 1'b1, 64'h0,        LMAX,  1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 64'h8008, 64'h0,                 SWNEW, 1'b1, 64'(SWNEW),   LMAX,  1'b1));

    reset_n   = 1'b1;
    memWrite  = 1'b0;
    memRead   = 1'b0;
    aluResult = '0;
    writeData = '0;
    switches  = '0;
    #1 reset_n = 1'b0;
    #1 checkResetOutputs("power_on_reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Mid-run reset: outputs clear without a clock edge, counter restarts from 0
    reset_n = 1'b0;
    #1 checkResetOutputs("midrun_reset");
    #1 reset_n = 1'b1;
    applyStimulus(mk(1'b0, 1'b1, 64'h8010, 64'h0, SWNEW, 1'b1, 64'h0, 27'h0, 1'b0), "post_reset_cnt0");
    applyStimulus(mk(1'b0, 1'b1, 64'h8010, 64'h0, SWNEW, 1'b1, 64'h1, 27'h0, 1'b0), "post_reset_cnt1");

    // Counter sitting at all-ones wraps to zero on the next read
    force dut.cnt_q = {64{1'b1}};
    applyStimulus(mk(1'b0, 1'b1, 64'h8010, 64'h0, SWNEW, 1'b1, 64'h0, 27'h0, 1'b0), "cnt_wrap");
    release dut.cnt_q;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mem_stage_mmio.md
Name: mem_stage_mmio

Overview:
- Parametrised MEM stage for the pipelined ARMv8 core: a synchronous data RAM plus a small memory-mapped I/O region (LEDs, switches, cycle counter), selected by address decode.
- Adds a registered read path with a valid strobe, a switch synchroniser, a free-running cycle counter and a sticky misaligned-access fault.
- Sits between the EX/MEM and MEM/WB pipeline registers. read_data, read_valid and alu_result_out are the MEM/WB-side outputs.

Parameters:
- DATA_W, 64, data/address width in bits.
- RAM_DEPTH, 1024, number of DATA_W-bit words in data RAM (power of two).
- IO_BIT, 15, lowest address bit of the I/O-select field; addr[DATA_W-1:IO_BIT]==0 selects RAM, otherwise I/O.
- SW_W, 18, switch input width.
- LED_W, 27, LED output width.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_write  in  1  store request this cycle.
- mem_read  in  1  load request this cycle.
- alu_result  in  DATA_W  effective byte address from EX.
- write_data  in  DATA_W  store data.
- switches  in  SW_W  asynchronous board switches.
- read_data  out  DATA_W  load result, registered.
- read_valid  out  1  one-cycle strobe: read_data holds a completed load.
- alu_result_out  out  DATA_W  alu_result delayed one cycle, aligned with read_data.
- leds  out  LED_W  LED register.
- addr_fault  out  1  sticky misaligned-access flag.

Behaviour:
- Reset (async, reset_n=0): read_data=0, read_valid=0, alu_result_out=0, leds=0, counter=0, switch sync flops=0, addr_fault=0. RAM contents are not reset. Release is synchronous to the next edge.

Decode:
- Access is aligned iff alu_result[2:0]==0.
- RAM region: RAM index = alu_result[3 +: log2(RAM_DEPTH)]; higher address bits below IO_BIT are ignored (aliasing).
- I/O region: register select = alu_result[4:3]:
  - 0: LED (R/W).
  - 1: switches (RO; writes ignored).
  - 2: cycle counter (R; a write clears it).
  - 3: reserved (reads 0, writes ignored).

Writes:
- Take effect at the edge of the request cycle.
- RAM: the word is written with write_data.
- LED: leds <= write_data[LED_W-1:0].

Reads:
- Latency 1. A request in cycle N gives read_data and read_valid=1 after edge N.
- When no read completes, read_valid=0 and read_data holds its previous value.
- I/O read values are zero-extended to DATA_W.
- A read from a RAM word written in the previous cycle returns the new data.

Simultaneous mem_read and mem_write:
- The write is performed and the read is dropped (read_valid=0).

Misaligned access (read or write with alu_result[2:0]!=0):
- The access is suppressed: no state change, read_valid=0.
- addr_fault is set and stays 1 until reset.

alu_result_out:
- Registered every cycle regardless of request.

Switches:
- Pass through a 2-flop synchroniser; reads return the synchronised value.
- A change is visible to a read issued 2 cycles after the input changes.

Counter:
- DATA_W bits, increments every cycle, wraps from all-ones to 0.
- On the edge of a write to register 2 it loads 0; it then increments normally from the next edge (counter write beats increment).

Test Plan:
- Reset: assert reset_n=0 mid-run, no clock edge -> all outputs 0 immediately. After release, counter reads 0 then increments by 1 per cycle.
- RAM: write 0xDEADBEEF_CAFEF00D to address 0x40, read 0x40 next cycle -> read_data=0xDEADBEEF_CAFEF00D with read_valid=1 exactly one cycle later. Read 0x40+8*RAM_DEPTH (alias) -> same value.
- LED: write 0xFFFF_FFFF_FFFF_FFFF to 0x8000 -> leds=0x7FFFFFF. Read 0x8000 -> read_data=0x0000_0000_07FF_FFFF. Write to 0x8008 (switches) -> leds unchanged, no other state change.
- Switches: set switches=0x2AAAA. A read of 0x8008 issued 1 cycle later returns the old value; issued 2 cycles later returns 0x2AAAA.
- Counter: write to 0x8010 in cycle N. Read in cycle N+1 -> 1; counter preloaded near wrap (force all-ones) -> next read shows 0.
- Fault and simultaneous requests: write to 0x44 (misaligned) -> RAM unchanged, addr_fault=1 and stays 1. mem_read and mem_write both high on 0x40 -> write done, read_valid=0.
